// File: rtl/fitness_eval_pkg.sv
// Shared sizing, coefficient array types and the unpacking helpers for fitness_eval.
package fitness_eval_pkg;
  localparam int NUM_PARTICLE_TYPE        = 3;
  localparam int DATA_WIDTH               = 4;
  localparam int PARTICLE_LENGTH          = 2;
  localparam int LATTICE_LENGTH           = 11;
  localparam int SELF_FIT_LENGTH          = 10;
  localparam int SELF_ENERGY_VEC_LENGTH   = NUM_PARTICLE_TYPE * DATA_WIDTH;
  localparam int INTERATION_MATRIX_LENGTH = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
  localparam int INDIVIDUAL_LENGTH        = LATTICE_LENGTH * PARTICLE_LENGTH;
  localparam int POP_SIZE                 = 50;
  localparam int IDX_WIDTH                = $clog2(POP_SIZE);
  localparam int SUM_WIDTH                = $clog2(LATTICE_LENGTH * (2**DATA_WIDTH - 1) + 1);
  localparam int ACC_WIDTH                = SUM_WIDTH + 2;

  typedef logic [DATA_WIDTH-1:0]      coef_t;
  typedef logic [PARTICLE_LENGTH-1:0] code_t;
  typedef coef_t [NUM_PARTICLE_TYPE-1:0] se_arr_t;
  typedef coef_t [NUM_PARTICLE_TYPE-1:0][NUM_PARTICLE_TYPE-1:0] mat_arr_t;

  // Out-of-range code: used as the predecessor of position 0 so it adds no interaction.
  localparam code_t NO_PARTICLE = '1;
  localparam logic [IDX_WIDTH-1:0] LAST_RESULT = IDX_WIDTH'(POP_SIZE - 1);

  function automatic se_arr_t unpack_se(input logic [SELF_ENERGY_VEC_LENGTH-1:0] vec);
    se_arr_t arr;
    for (int i = 0; i < NUM_PARTICLE_TYPE; i++)
      arr[i] = vec[(NUM_PARTICLE_TYPE-1-i)*DATA_WIDTH +: DATA_WIDTH];
    return arr;
  endfunction

  function automatic mat_arr_t unpack_mat(input logic [INTERATION_MATRIX_LENGTH-1:0] vec);
    mat_arr_t arr;
    for (int a = 0; a < NUM_PARTICLE_TYPE; a++)
      for (int b = 0; b < NUM_PARTICLE_TYPE; b++)
        arr[a][b] = vec[(NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE-1-(a*NUM_PARTICLE_TYPE+b))*DATA_WIDTH +: DATA_WIDTH];
    return arr;
  endfunction
endpackage

// File: rtl/fitness_lut.sv
// Combinational self-energy and pairwise-interaction lookup for one lattice position.
// No latency, no flow control; codes beyond the particle table contribute zero.
module fitness_lut
  import fitness_eval_pkg::*;
(
  input  se_arr_t  se,
  input  mat_arr_t mat,
  input  code_t    code_prev,
  input  code_t    code,
  output coef_t    self_val,
  output coef_t    inter_val
);
  always_comb begin
    self_val  = '0;
    inter_val = '0;
    if (int'(code) < NUM_PARTICLE_TYPE) begin
      self_val = se[code];
      if (int'(code_prev) < NUM_PARTICLE_TYPE)
        inter_val = mat[code_prev][code];
    end
  end
endmodule

// File: rtl/fitness_eval.sv
// Pipelined lattice energy evaluator: 3-cycle fixed latency, one individual per clock.
// Never stalls; coefficients load through a two-state IDLE/LOAD handshake.
module fitness_eval
  import fitness_eval_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_n,
  input  logic [SELF_ENERGY_VEC_LENGTH-1:0]   self_energy_vec_i,
  input  logic [INTERATION_MATRIX_LENGTH-1:0] interact_matrix_i,
  input  logic [INDIVIDUAL_LENGTH-1:0]        individual_vec_i,
  input  logic                                in_valid_i,
  input  logic                                Set_data_i,
  input  logic [IDX_WIDTH-1:0]                ind_idx_i,
  output logic                                out_valid_ff_o,
  output logic                                done_ff_o,
  output logic [SELF_FIT_LENGTH-1:0]          total_energy_ff_o,
  output logic [IDX_WIDTH-1:0]                ind_wb_idx_ff_o
);
  typedef enum logic {IDLE, LOAD} state_t;

  state_t                                state;
  logic [SELF_ENERGY_VEC_LENGTH-1:0]     se_vec_q;
  logic [INTERATION_MATRIX_LENGTH-1:0]   mat_vec_q;
  logic [IDX_WIDTH-1:0]                  res_cnt;

  se_arr_t  se_arr;
  mat_arr_t mat_arr;
  coef_t    lut_self  [LATTICE_LENGTH];
  coef_t    lut_inter [LATTICE_LENGTH];

  coef_t                s1_self  [LATTICE_LENGTH];
  coef_t                s1_inter [LATTICE_LENGTH];
  logic                 s1_vld;
  logic [IDX_WIDTH-1:0] s1_idx;
  logic [SUM_WIDTH-1:0] s2_self, s2_inter, self_sum, inter_sum;
  logic                 s2_vld;
  logic [IDX_WIDTH-1:0] s2_idx;
  logic [ACC_WIDTH-1:0] acc;

  assign se_arr  = unpack_se(se_vec_q);
  assign mat_arr = unpack_mat(mat_vec_q);

  for (genvar j = 0; j < LATTICE_LENGTH; j++) begin : g_pos
    code_t code_prev;
    if (j == 0) begin : g_head
      assign code_prev = NO_PARTICLE;
    end else begin : g_body
      assign code_prev = individual_vec_i[PARTICLE_LENGTH*(j-1) +: PARTICLE_LENGTH];
    end
    fitness_lut u_lut (
      .se        (se_arr),
      .mat       (mat_arr),
      .code_prev (code_prev),
      .code      (individual_vec_i[PARTICLE_LENGTH*j +: PARTICLE_LENGTH]),
      .self_val  (lut_self[j]),
      .inter_val (lut_inter[j])
    );
  end

  // Coefficient load FSM and result counter; counter clear wins over a coincident result.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      se_vec_q  <= '0;
      mat_vec_q <= '0;
      res_cnt   <= '0;
      done_ff_o <= 1'b0;
    end else begin
      done_ff_o <= 1'b0;
      case (state)
        IDLE: if (Set_data_i) state <= LOAD;
        LOAD: begin
          se_vec_q  <= self_energy_vec_i;
          mat_vec_q <= interact_matrix_i;
          state     <= Set_data_i ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (state == IDLE && Set_data_i) begin
        res_cnt <= '0;
      end else if (s2_vld) begin
        if (res_cnt == LAST_RESULT) begin
          res_cnt   <= '0;
          done_ff_o <= 1'b1;
        end else begin
          res_cnt <= res_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    self_sum  = '0;
    inter_sum = '0;
    for (int j = 0; j < LATTICE_LENGTH; j++) begin
      self_sum  = self_sum  + SUM_WIDTH'(s1_self[j]);
      inter_sum = inter_sum + SUM_WIDTH'(s1_inter[j]);
    end
  end

  assign acc = ACC_WIDTH'(s2_self) + (ACC_WIDTH'(s2_inter) << 1);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < LATTICE_LENGTH; j++) begin
        s1_self[j]  <= '0;
        s1_inter[j] <= '0;
      end
      s1_vld            <= 1'b0;
      s1_idx            <= '0;
      s2_self           <= '0;
      s2_inter          <= '0;
      s2_vld            <= 1'b0;
      s2_idx            <= '0;
      out_valid_ff_o    <= 1'b0;
      total_energy_ff_o <= '0;
      ind_wb_idx_ff_o   <= '0;
    end else begin
      for (int j = 0; j < LATTICE_LENGTH; j++) begin
        s1_self[j]  <= lut_self[j];
        s1_inter[j] <= lut_inter[j];
      end
      s1_vld         <= in_valid_i;
      s1_idx         <= ind_idx_i;
      s2_self        <= self_sum;
      s2_inter       <= inter_sum;
      s2_vld         <= s1_vld;
      s2_idx         <= s1_idx;
      out_valid_ff_o <= s2_vld;
      if (s2_vld) begin
        total_energy_ff_o <= SELF_FIT_LENGTH'(acc);
        ind_wb_idx_ff_o   <= s2_idx;
      end
    end
  end
endmodule

// File: tb/tb_fitness_eval.sv
// Directed and randomized bench for fitness_eval against an arithmetic reference model.
module tb_fitness_eval;
  import fitness_eval_pkg::*;

  logic                                clk_i = 1'b0;
  logic                                rst_n;
  logic [SELF_ENERGY_VEC_LENGTH-1:0]   self_energy_vec_i;
  logic [INTERATION_MATRIX_LENGTH-1:0] interact_matrix_i;
  logic [INDIVIDUAL_LENGTH-1:0]        individual_vec_i;
  logic                                in_valid_i;
  logic                                Set_data_i;
  logic [IDX_WIDTH-1:0]                ind_idx_i;
  logic                                out_valid_ff_o;
  logic                                done_ff_o;
  logic [SELF_FIT_LENGTH-1:0]          total_energy_ff_o;
  logic [IDX_WIDTH-1:0]                ind_wb_idx_ff_o;

  fitness_eval dut (
    .clk_i             (clk_i),
    .rst_n             (rst_n),
    .self_energy_vec_i (self_energy_vec_i),
    .interact_matrix_i (interact_matrix_i),
    .individual_vec_i  (individual_vec_i),
    .in_valid_i        (in_valid_i),
    .Set_data_i        (Set_data_i),
    .ind_idx_i         (ind_idx_i),
    .out_valid_ff_o    (out_valid_ff_o),
    .done_ff_o         (done_ff_o),
    .total_energy_ff_o (total_energy_ff_o),
    .ind_wb_idx_ff_o   (ind_wb_idx_ff_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {bit vld; int e; int idx;} exp_t;

  int   tests = 0;
  int   fails = 0;
  int   se_m [3];
  int   m_m  [3][3];
  exp_t pipe_q[$];
  int   hold_e, hold_idx, res_cnt, done_seen;

  function automatic int ref_energy(input logic [INDIVIDUAL_LENGTH-1:0] ind);
    int p [LATTICE_LENGTH];
    int s = 0;
    int inter = 0;
    for (int j = 0; j < LATTICE_LENGTH; j++) p[j] = int'(ind[PARTICLE_LENGTH*j +: PARTICLE_LENGTH]);
    for (int j = 0; j < LATTICE_LENGTH; j++) if (p[j] < 3) s += se_m[p[j]];
    for (int j = 1; j < LATTICE_LENGTH; j++)
      if (p[j] < 3 && p[j-1] < 3) inter += m_m[p[j-1]][p[j]];
    return (s + 2 * inter) % 1024;
  endfunction

  function automatic logic [INDIVIDUAL_LENGTH-1:0] uniform(input int code);
    logic [INDIVIDUAL_LENGTH-1:0] v;
    for (int j = 0; j < LATTICE_LENGTH; j++) v[PARTICLE_LENGTH*j +: PARTICLE_LENGTH] = code_t'(code);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit vld, input logic [INDIVIDUAL_LENGTH-1:0] ind, input int idx, input bit set);
    exp_t e, o;
    bit   exp_done;
    in_valid_i       = vld;
    individual_vec_i = ind;
    ind_idx_i        = IDX_WIDTH'(idx);
    Set_data_i       = set;
    e.vld = vld;
    e.e   = ref_energy(ind);
    e.idx = idx;
    @(posedge clk_i);
    pipe_q.push_back(e);
    o = '{0, 0, 0};
    if (pipe_q.size() == 3) o = pipe_q.pop_front();
    exp_done = 1'b0;
    if (o.vld) begin
      hold_e   = o.e;
      hold_idx = o.idx;
      res_cnt++;
      if (res_cnt == POP_SIZE) begin
        exp_done = 1'b1;
        res_cnt  = 0;
      end
    end
    if (set) begin
      res_cnt  = 0;
      exp_done = 1'b0;
    end
    @(negedge clk_i);
    if (done_ff_o === 1'b1) done_seen++;
    check("out_valid", out_valid_ff_o, o.vld);
    check("energy", total_energy_ff_o, hold_e);
    check("index", ind_wb_idx_ff_o, hold_idx);
    check("done", done_ff_o, exp_done);
  endtask

  task automatic load_coeffs();
    cycle(0, '0, 0, 1);
    self_energy_vec_i = 12'h123;
    interact_matrix_i = 36'hA41_4A5_15A;
    cycle(0, '0, 0, 0);
    self_energy_vec_i = '0;
    interact_matrix_i = '0;
    se_m = '{1, 2, 3};
    m_m  = '{'{10, 4, 1}, '{4, 10, 5}, '{1, 5, 10}};
  endtask

  logic [INDIVIDUAL_LENGTH-1:0] alt;

  initial begin
    rst_n = 1'b0;
    self_energy_vec_i = '0;
    interact_matrix_i = '0;
    individual_vec_i  = '0;
    in_valid_i = 1'b0;
    Set_data_i = 1'b0;
    ind_idx_i  = '0;
    se_m = '{0, 0, 0};
    m_m  = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    hold_e = 0; hold_idx = 0; res_cnt = 0; done_seen = 0;
    for (int j = 0; j < LATTICE_LENGTH; j++) alt[PARTICLE_LENGTH*j +: PARTICLE_LENGTH] = code_t'(j % 2);

    repeat (2) @(negedge clk_i);
    check("rst_valid", out_valid_ff_o, 0);
    check("rst_done", done_ff_o, 0);
    check("rst_energy", total_energy_ff_o, 0);
    check("rst_index", ind_wb_idx_ff_o, 0);
    rst_n = 1'b1;

    load_coeffs();
    cycle(1, uniform(0), 7, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    check("zero_ind_const", total_energy_ff_o, 211);

    cycle(1, uniform(1), 1, 0);
    cycle(1, uniform(2), 2, 0);
    cycle(0, '0, 0, 0);
    check("ones_const", total_energy_ff_o, 222);
    check("ones_idx_const", ind_wb_idx_ff_o, 1);
    cycle(0, '0, 0, 0);
    check("twos_const", total_energy_ff_o, 233);
    check("twos_idx_const", ind_wb_idx_ff_o, 2);

    cycle(1, alt, 3, 0);
    cycle(1, uniform(3), 4, 0);
    cycle(0, '0, 0, 0);
    check("alt_const", total_energy_ff_o, 96);
    cycle(0, '0, 0, 0);
    check("code3_const", total_energy_ff_o, 0);
    check("code3_valid", out_valid_ff_o, 1);
    repeat (2) cycle(0, '0, 0, 0);

    // 50 back-to-back random individuals after a fresh load.
    load_coeffs();
    done_seen = 0;
    for (int i = 0; i < POP_SIZE; i++)
      cycle(1, INDIVIDUAL_LENGTH'($urandom()), i, 0);
    repeat (3) cycle(0, '0, 0, 0);
    check("done_pulses", done_seen, 1);

    // Random gaps, then reset mid-stream.
    for (int i = 0; i < 20; i++)
      cycle(bit'($urandom_range(0, 1)), INDIVIDUAL_LENGTH'($urandom()), int'($urandom_range(0, POP_SIZE-1)), 0);
    cycle(1, uniform(1), 9, 0);
    cycle(1, uniform(2), 10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid_ff_o, 0);
    check("midrst_energy", total_energy_ff_o, 0);
    check("midrst_index", ind_wb_idx_ff_o, 0);
    check("midrst_done", done_ff_o, 0);
    pipe_q.delete();
    hold_e = 0; hold_idx = 0; res_cnt = 0;
    se_m = '{0, 0, 0};
    m_m  = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    @(negedge clk_i);
    rst_n = 1'b1;

    cycle(1, uniform(0), 12, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    check("postrst_energy_const", total_energy_ff_o, 0);
    check("postrst_idx_const", ind_wb_idx_ff_o, 12);

    load_coeffs();
    cycle(1, alt, 13, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    check("reload_alt_const", total_energy_ff_o, 96);
    repeat (2) cycle(0, '0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
